// File: rtl/uart_pkg.sv
// uart_pkg: shared UART link types and defaults for uart_rx and uart_tx
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
    localparam int D_W_DEF = 8;
    localparam int B_TICK_DEF = 16;
    localparam logic UART_IDLE_LVL = 1'b1;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line, resets to the idle level
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [1:0] ff;
    always_ff @(posedge clk) begin
        if (!rst) ff <= {2{UART_IDLE_LVL}};
        else ff <= {ff[0], d};
    end
    assign q = ff[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with mid-bit sampling
// UART_RX_PARITY_EN adds an even-parity bit between data and stop
module uart_rx
    import uart_pkg::*;
#(
    parameter int D_W    = D_W_DEF,
    parameter int B_TICK = B_TICK_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           baud_clk,
    input  logic           rx_in,
    output logic           baud_en,
    output logic [D_W-1:0] output_data,
    output logic           rx_done,
    output logic           frame_err
);
    localparam int TW = $clog2(B_TICK);
    localparam int BW = $clog2(D_W);
    localparam logic [TW-1:0] T_MID = TW'(B_TICK / 2 - 1);
    localparam logic [TW-1:0] T_END = TW'(B_TICK - 1);
    localparam logic [BW-1:0] B_LAST = BW'(D_W - 1);
    uart_state_t state;
    logic rx_s, rx_q, stop_ok;
    logic [TW-1:0] t_counter;
    logic [BW-1:0] bit_cnt;
    logic [D_W-1:0] shift;
`ifdef UART_RX_PARITY_EN
    logic par_err;
    assign stop_ok = rx_s & ~par_err;
`else
    assign stop_ok = rx_s;
`endif
    uart_rx_sync u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx_in),
        .q  (rx_s)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            rx_q        <= UART_IDLE_LVL;
            t_counter   <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            baud_en     <= 1'b0;
            output_data <= '0;
            rx_done     <= 1'b0;
            frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err     <= 1'b0;
`endif
        end else begin
            rx_q      <= rx_s;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: if (rx_q && !rx_s) begin
                    state     <= START;
                    t_counter <= '0;
                    baud_en   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    par_err   <= 1'b0;
`endif
                end
                START: if (baud_clk) begin
                    if (t_counter == T_MID) begin
                        t_counter <= '0;
                        bit_cnt   <= '0;
                        state     <= rx_s ? IDLE : DATA;
                        baud_en   <= ~rx_s;
                    end else t_counter <= t_counter + 1'b1;
                end
                DATA: if (baud_clk) begin
                    if (t_counter == T_END) begin
                        t_counter <= '0;
                        shift     <= {rx_s, shift[D_W-1:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (bit_cnt == B_LAST) state <= PARITY;
`else
                        if (bit_cnt == B_LAST) state <= STOP;
`endif
                    end else t_counter <= t_counter + 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (baud_clk) begin
                    if (t_counter == T_END) begin
                        t_counter <= '0;
                        par_err   <= ^shift ^ rx_s;
                        state     <= STOP;
                    end else t_counter <= t_counter + 1'b1;
                end
`endif
                STOP: if (baud_clk) begin
                    if (t_counter == T_END) begin
                        t_counter <= '0;
                        state     <= IDLE;
                        baud_en   <= 1'b0;
                        if (stop_ok) begin
                            output_data <= shift;
                            rx_done     <= 1'b1;
                        end else frame_err <= 1'b1;
                    end else t_counter <= t_counter + 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    t_counter <= '0;
                    baud_en   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx, B_TICK=16 with a baud tick every 4 clk
module tb_uart_rx;
    localparam int BIT_CLK = 64;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx_in = 1'b1;
    logic baud_clk;
    logic baud_en, rx_done, frame_err;
    logic [7:0] output_data;
    logic [1:0] div = 2'd0;
    int n_chk = 0;
    int n_pass = 0;
    int err_cnt = 0;
    int long_cnt = 0;
    int both_cnt = 0;
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;
    logic [7:0] done_q[$];

    uart_rx #(.D_W(8), .B_TICK(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_clk   (baud_clk),
        .rx_in      (rx_in),
        .baud_en    (baud_en),
        .output_data(output_data),
        .rx_done    (rx_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) div <= div + 2'd1;
    assign baud_clk = (div == 2'd3);

    always @(negedge clk) begin
        if (rx_done) done_q.push_back(output_data);
        if (frame_err) err_cnt++;
        if ((rx_done && prev_done) || (frame_err && prev_err)) long_cnt++;
        if (rx_done && frame_err) both_cnt++;
        prev_done = rx_done;
        prev_err = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip = 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d ^ par_flip);
`endif
        send_bit(stop);
    endtask

    int d0, e0;

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check("rst_baud_en", baud_en, 1'b0);
        check("rst_data", output_data, 8'h00);
        check("rst_done", rx_done, 1'b0);
        check("rst_err", frame_err, 1'b0);
        rst = 1'b1;
        send_bit(1'b1);
        // T1: single good frame
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (100) @(posedge clk);
                #1;
                check("t1_baud_en_busy", baud_en, 1'b1);
            end
        join
        send_bit(1'b1);
        check("t1_done_cnt", done_q.size(), 1);
        check("t1_data", done_q.size() > 0 ? done_q[0] : 8'hxx, 8'hA5);
        check("t1_out", output_data, 8'hA5);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_baud_en_idle", baud_en, 1'b0);
        // T2: 3-tick low glitch is a false start
        d0 = done_q.size();
        e0 = err_cnt;
        rx_in = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rx_in = 1'b1;
        check("t2_baud_en_busy", baud_en, 1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        check("t2_baud_en_idle", baud_en, 1'b0);
        check("t2_done", done_q.size() - d0, 0);
        check("t2_err", err_cnt - e0, 0);
        check("t2_out", output_data, 8'hA5);
        // T3: bad stop bit
        d0 = done_q.size();
        e0 = err_cnt;
        send_frame(8'h3C, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("t3_err", err_cnt - e0, 1);
        check("t3_done", done_q.size() - d0, 0);
        check("t3_out", output_data, 8'hA5);
        check("t3_baud_en_idle", baud_en, 1'b0);
        // T4: back-to-back frames, single stop bit
        d0 = done_q.size();
        e0 = err_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        send_bit(1'b1);
        check("t4_done", done_q.size() - d0, 3);
        check("t4_err", err_cnt - e0, 0);
        check("t4_v0", done_q.size() > d0 ? done_q[d0] : 8'hxx, 8'h00);
        check("t4_v1", done_q.size() > d0 + 1 ? done_q[d0+1] : 8'hxx, 8'hFF);
        check("t4_v2", done_q.size() > d0 + 2 ? done_q[d0+2] : 8'hxx, 8'h81);
        // T5: reset in the middle of data bit 4
        d0 = done_q.size();
        e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx_in = 1'b0;
        repeat (BIT_CLK / 2) @(posedge clk);
        #1;
        check("t5_busy_before_rst", baud_en, 1'b1);
        rst = 1'b0;
        rx_in = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rst_baud_en", baud_en, 1'b0);
        check("t5_rst_data", output_data, 8'h00);
        check("t5_rst_done", rx_done, 1'b0);
        check("t5_rst_err", frame_err, 1'b0);
        rst = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        check("t5_no_pulse", (done_q.size() - d0) + (err_cnt - e0), 0);
        send_frame(8'h5A, 1'b1);
        send_bit(1'b1);
        check("t5_done", done_q.size() - d0, 1);
        check("t5_data", output_data, 8'h5A);
`ifdef UART_RX_PARITY_EN
        // T6: 0x07 has odd weight, so the even-parity bit must be 1
        d0 = done_q.size();
        e0 = err_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        send_bit(1'b1);
        check("t6_bad_err", err_cnt - e0, 1);
        check("t6_bad_done", done_q.size() - d0, 0);
        check("t6_bad_out", output_data, 8'h5A);
        send_frame(8'h07, 1'b1);
        send_bit(1'b1);
        check("t6_good_done", done_q.size() - d0, 1);
        check("t6_good_out", output_data, 8'h07);
        check("t6_good_err", err_cnt - e0, 1);
`endif
        check("pulse_width", long_cnt, 0);
        check("pulse_exclusive", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
